// File: rtl/score_pkg.sv
// Shared types and constants for the Pong scoreboard: FSM state, segment patterns,
// and a constant helper that turns a binary score into packed BCD.
package score_pkg;

  typedef enum logic {PLAY, WON} score_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} patterns for digits 0..9, dp always off.
  localparam logic [7:0] SEG_LUT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  function automatic logic [31:0] to_bcd(input int unsigned value);
    logic [31:0] bcd;
    int unsigned rest;
    bcd  = '0;
    rest = value;
    for (int i = 0; i < 8; i++) begin
      bcd[i*4 +: 4] = 4'(rest % 10);
      rest          = rest / 10;
    end
    return bcd;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// One BCD digit to an active-low 7-segment pattern; non-decimal codes and the
// blank request both turn every segment off.
module bcd_seg_decode
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [7:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    if (!blank && (bcd <= 4'd9)) begin
      seg_n = SEG_LUT[bcd];
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Pong scoreboard: per-player saturating BCD scores, win detection with lowest-index
// tie-break, and 7-segment outputs where the winner's digits blink once the game is won.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int DIGITS       = 2,
  parameter int WIN_SCORE    = 11,
  parameter int BLINK_FRAMES = 16,
  localparam int WIN_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            frame_tick,
  input  logic [NUM_PLAYERS-1:0]          point,
  input  logic                            clear,
  output logic [NUM_PLAYERS*DIGITS*4-1:0] score_bcd,
  output logic [NUM_PLAYERS*DIGITS*8-1:0] seg_n,
  output logic                            game_over,
  output logic [WIN_W-1:0]                winner
);

  localparam int SCORE_W = DIGITS * 4;
  localparam int CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [31:0]        WIN_BCD_FULL = to_bcd(WIN_SCORE);
  localparam logic [SCORE_W-1:0] WIN_BCD      = WIN_BCD_FULL[SCORE_W-1:0];
  localparam logic [CNT_W-1:0]   BLINK_LAST   = CNT_W'(BLINK_FRAMES - 1);

  score_state_t                     state;
  logic [NUM_PLAYERS*SCORE_W-1:0]   score_reg;
  logic [CNT_W-1:0]                 blink_cnt;
  logic                             blink_on;
  logic                             game_over_reg;
  logic [WIN_W-1:0]                 winner_reg;

  logic [NUM_PLAYERS*SCORE_W-1:0]   score_inc;
  logic [NUM_PLAYERS-1:0]           win_hit;
  logic                             win_any;
  logic [WIN_W-1:0]                 win_idx;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      logic [SCORE_W-1:0] cur;
      logic [SCORE_W-1:0] nxt;
      logic               blank;

      assign cur = score_reg[gi*SCORE_W +: SCORE_W];

      // Ripple the +1 through the digits; an all-nines score holds instead of wrapping.
      always_comb begin : inc_comb
        logic carry;
        carry = 1'b1;
        nxt   = cur;
        for (int d = 0; d < DIGITS; d++) begin
          if (carry) begin
            if (cur[d*4 +: 4] == 4'd9) begin
              nxt[d*4 +: 4] = 4'd0;
            end else begin
              nxt[d*4 +: 4] = cur[d*4 +: 4] + 4'd1;
              carry         = 1'b0;
            end
          end
        end
        if (carry) begin
          nxt = cur;
        end
      end

      assign score_inc[gi*SCORE_W +: SCORE_W] = nxt;
      assign win_hit[gi] = point[gi] && (nxt == WIN_BCD);
      assign blank = game_over_reg && (winner_reg == WIN_W'(gi)) && !blink_on;

      for (gj = 0; gj < DIGITS; gj++) begin : g_digit
        bcd_seg_decode u_dec (
          .bcd   (score_reg[(gi*DIGITS + gj)*4 +: 4]),
          .blank (blank),
          .seg_n (seg_n[(gi*DIGITS + gj)*8 +: 8])
        );
      end
    end
  endgenerate

  // Scan from the top down so the lowest winning index is the one that sticks.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (win_hit[p]) begin
        win_any = 1'b1;
        win_idx = WIN_W'(p);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= PLAY;
      score_reg     <= '0;
      blink_cnt     <= '0;
      blink_on      <= 1'b1;
      game_over_reg <= 1'b0;
      winner_reg    <= '0;
    end else if (clear) begin
      state         <= PLAY;
      score_reg     <= '0;
      blink_cnt     <= '0;
      blink_on      <= 1'b1;
      game_over_reg <= 1'b0;
      winner_reg    <= '0;
    end else begin
      case (state)
        PLAY: begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (point[p]) begin
              score_reg[p*SCORE_W +: SCORE_W] <= score_inc[p*SCORE_W +: SCORE_W];
            end
          end
          if (win_any) begin
            state         <= WON;
            game_over_reg <= 1'b1;
            winner_reg    <= win_idx;
          end
        end
        WON: begin
          if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              blink_on  <= ~blink_on;
            end else begin
              blink_cnt <= blink_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

  assign score_bcd = score_reg;
  assign game_over = game_over_reg;
  assign winner    = winner_reg;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench: two scoreboard configurations driven every cycle, expected outputs
// from an integer-score reference model queued per instance and checked by monitors.
module tb_score_display_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, ft0, ft1, clr0, clr1;
  logic [1:0]  pt0;
  logic [2:0]  pt1;
  logic [15:0] sb0;
  logic [31:0] sg0;
  logic        go0;
  logic [0:0]  w0;
  logic [11:0] sb1;
  logic [23:0] sg1;
  logic        go1;
  logic [1:0]  w1;

  score_display_ctrl #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(11), .BLINK_FRAMES(4)) u0 (
    .Clk(clk), .Reset(rst0), .frame_tick(ft0), .point(pt0), .clear(clr0),
    .score_bcd(sb0), .seg_n(sg0), .game_over(go0), .winner(w0)
  );

  score_display_ctrl #(.NUM_PLAYERS(3), .DIGITS(1), .WIN_SCORE(9), .BLINK_FRAMES(16)) u1 (
    .Clk(clk), .Reset(rst1), .frame_tick(ft1), .point(pt1), .clear(clr1),
    .score_bcd(sb1), .seg_n(sg1), .game_over(go1), .winner(w1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int cfg_np[2] = '{2, 3};
  int cfg_dg[2] = '{2, 1};
  int cfg_ws[2] = '{11, 9};
  int cfg_bf[2] = '{4, 16};

  // Reference model: plain integer scores, a won flag and a frame counter per instance.
  int m_score[2][4];
  bit m_won[2];
  int m_winner[2];
  int m_bcnt[2];
  bit m_bon[2];

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct packed {
    logic [63:0]  score;
    logic [127:0] seg;
    logic         go;
    logic [1:0]   win;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic model_step(input int k, input logic [3:0] pt, input bit clr,
                            input bit ft, input bit rst);
    int maxv;
    maxv = 10 ** cfg_dg[k] - 1;
    if (rst || clr) begin
      for (int i = 0; i < 4; i++) m_score[k][i] = 0;
      m_won[k] = 0; m_winner[k] = 0; m_bcnt[k] = 0; m_bon[k] = 1;
    end else if (!m_won[k]) begin
      for (int i = 0; i < cfg_np[k]; i++)
        if (pt[i] && m_score[k][i] < maxv) m_score[k][i]++;
      for (int i = cfg_np[k] - 1; i >= 0; i--)
        if (pt[i] && m_score[k][i] == cfg_ws[k]) begin
          m_won[k] = 1; m_winner[k] = i;
        end
    end else if (ft) begin
      m_bcnt[k]++;
      if (m_bcnt[k] == cfg_bf[k]) begin
        m_bcnt[k] = 0; m_bon[k] = !m_bon[k];
      end
    end
  endtask

  function automatic exp_t make_exp(input int k);
    exp_t e;
    int idx, v;
    e = '0;
    for (int p = 0; p < cfg_np[k]; p++)
      for (int d = 0; d < cfg_dg[k]; d++) begin
        idx = p * cfg_dg[k] + d;
        v   = (m_score[k][p] / (10 ** d)) % 10;
        e.score[idx*4 +: 4] = 4'(v);
        e.seg[idx*8 +: 8]   = (m_won[k] && p == m_winner[k] && !m_bon[k]) ? 8'hFF : seg_tab[v];
      end
    e.go  = m_won[k];
    e.win = 2'(m_winner[k]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic step(input logic [1:0] p, input bit c, input bit f, input bit r);
    logic [2:0] p1;
    bit c1, f1;
    p1 = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
    c1 = ($urandom_range(0, 59) == 0);
    f1 = 1'($urandom_range(0, 1));
    @(negedge clk);
    pt0 = p;  clr0 = c;  ft0 = f;  rst0 = r;
    pt1 = p1; clr1 = c1; ft1 = f1; rst1 = r;
    model_step(0, {2'b00, p}, c, f, r);
    q0.push_back(make_exp(0));
    model_step(1, {1'b0, p1}, c1, f1, r);
    q1.push_back(make_exp(1));
  endtask

  initial begin : mon0
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        $display("u0 t=%0t score=%h seg=%h over=%b winner=%0d", $time, sb0, sg0, go0, w0);
        chk("u0 score_bcd", 128'(sb0), 128'(e.score[15:0]));
        chk("u0 seg_n", 128'(sg0), 128'(e.seg[31:0]));
        chk("u0 game_over", 128'(go0), 128'(e.go));
        if (e.go) chk("u0 winner", 128'(w0), 128'(e.win[0]));
      end
    end
  end

  initial begin : mon1
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("u1 score_bcd", 128'(sb1), 128'(e.score[11:0]));
        chk("u1 seg_n", 128'(sg1), 128'(e.seg[23:0]));
        chk("u1 game_over", 128'(go1), 128'(e.go));
        if (e.go) chk("u1 winner", 128'(w1), 128'(e.win));
      end
    end
  end

  initial begin : stim
    rst0 = 1'b1; rst1 = 1'b1; ft0 = 0; ft1 = 0; clr0 = 0; clr1 = 0; pt0 = '0; pt1 = '0;
    step(2'b00, 0, 0, 1);
    step(2'b00, 0, 0, 1);
    // Nine points then a tenth: units carry into tens.
    for (int i = 0; i < 10; i++) begin
      step(2'b01, 0, 0, 0);
      step(2'b00, 0, 1, 0);
    end
    step(2'b00, 1, 0, 0);
    // Player 1 reaches 11, then points are ignored while the winner blinks.
    for (int i = 0; i < 11; i++) step(2'b10, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(2'b11, 0, 1, 0);
    step(2'b11, 1, 0, 0);
    // Both at 10 then a simultaneous point: tie resolves to player 0.
    for (int i = 0; i < 10; i++) step(2'b11, 0, 0, 0);
    step(2'b11, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(2'($urandom_range(0, 3)), 0, 1, 0);
    step(2'b00, 1, 0, 0);
    // Reset in the middle of a 5/7 game.
    for (int i = 0; i < 5; i++) step(2'b01, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(2'b10, 0, 0, 0);
    step(2'b00, 0, 0, 1);
    step(2'b00, 0, 0, 0);
    for (int i = 0; i < 1500; i++)
      step(2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3)),
           ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 399) == 0));
    step(2'b00, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", 128'(q0.size() + q1.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
